// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg -- shared types and constants for dpram_rr_arbiter.
//   state_t : arbiter FSM states (RESET, CLEAR, RUN)
//   tag_t   : read-tracking tag {valid, idx} carried alongside a RAM read
//   RAM_DEPTH / RD_LATENCY : macro depth and accept-to-response latency
package dpram_arb_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Requester index width covers the maximum of 4 requesters.
  localparam int IDX_W = 2;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  localparam int RAM_DEPTH  = 32;
  localparam int RD_LATENCY = 3;

endpackage

// File: rtl/dpram_rr_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin selector.
//   valid : request vector
//   ptr   : highest-priority requester this cycle
//   grant : one-hot grant (zero when nothing is valid); the first valid
//           requester found searching upward from ptr, modulo NREQ
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic found;

  // Double loop keeps every bit select constant; k is the search offset.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && valid[j] && (j == ((int'(ptr) + k) % NREQ))) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dpram_rr_arbiter.sv
// dpram_rr_arbiter -- shares one port of the dpram32x32_cb macro between
// NREQ requesters with round-robin arbitration, one operation per cycle.
//   CLK, RST            : clock, asynchronous active-high reset
//   req_valid/ready/we/addr/wdata : per-requester command handshake
//   rsp_valid, rsp_rdata : read response, 3 cycles after accept
//   busy                : high while not in RUN
//   A, I, O, CSB, WEB, OEB : RAM port pins (controls active low)
// Optional feature: define DPRAM_ARB_CLEAR_EN to zero-fill the RAM after
// every reset (CLEAR state, 32 write cycles) before any grant.
module dpram_rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     busy,
  output logic [ADDR_W-1:0]        A,
  output logic [DATA_W-1:0]        I,
  input  logic [DATA_W-1:0]        O,
  output logic                     CSB,
  output logic                     WEB,
  output logic                     OEB
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Tag stage 1 is the cycle the pins are driven, the last stage is the
  // cycle O is valid.
  localparam int LAST = RD_LATENCY - 1;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [NREQ-1:0]   grant;
  tag_t [LAST:1]     tag_pipe;
  logic              any_grant;
  logic              g_we;
  logic [IDX_W-1:0]  g_idx;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              rd_inflight;
`ifdef DPRAM_ARB_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;
`endif

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready = (state == ST_RUN) ? grant : '0;
  assign any_grant = |req_ready;
  assign busy      = (state != ST_RUN);

  // Winner's command mux.
  always_comb begin
    g_idx   = '0;
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_idx   = IDX_W'(i);
        g_we    = req_we[i];
        g_addr  = req_addr[i*ADDR_W +: ADDR_W];
        g_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output enable covers both the sample cycle and the data cycle of a read;
  // derived from reset-cleared flops so it idles immediately on RST.
  always_comb begin
    rd_inflight = 1'b0;
    for (int s = 1; s <= LAST; s++) rd_inflight = rd_inflight | tag_pipe[s].valid;
  end
  assign OEB = ~rd_inflight;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_RESET;
      rr_ptr    <= '0;
      A         <= '0;
      I         <= '0;
      CSB       <= 1'b1;
      WEB       <= 1'b1;
      tag_pipe  <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
`ifdef DPRAM_ARB_CLEAR_EN
      clr_cnt   <= '0;
`endif
    end else begin
      // Pins default to idle; A and I hold their last value.
      CSB <= 1'b1;
      WEB <= 1'b1;

      for (int s = 2; s <= LAST; s++) tag_pipe[s] <= tag_pipe[s-1];
      tag_pipe[1] <= '0;

      for (int i = 0; i < NREQ; i++)
        rsp_valid[i] <= tag_pipe[LAST].valid && (tag_pipe[LAST].idx == IDX_W'(i));
      if (tag_pipe[LAST].valid) rsp_rdata <= O;

      case (state)
        ST_RESET: begin
`ifdef DPRAM_ARB_CLEAR_EN
          state <= ST_CLEAR;
`else
          state <= ST_RUN;
`endif
        end
`ifdef DPRAM_ARB_CLEAR_EN
        ST_CLEAR: begin
          A       <= clr_cnt;
          I       <= '0;
          CSB     <= 1'b0;
          WEB     <= 1'b0;
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(RAM_DEPTH - 1)) begin
            clr_cnt <= '0;
            state   <= ST_RUN;
          end
        end
`endif
        ST_RUN: begin
          if (any_grant) begin
            A      <= g_addr;
            I      <= g_wdata;
            CSB    <= 1'b0;
            WEB    <= ~g_we;
            rr_ptr <= PW'((int'(g_idx) + 1) % NREQ);
            if (!g_we) tag_pipe[1] <= '{valid: 1'b1, idx: g_idx};
          end
        end
        default: state <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// tb_dpram_rr_arbiter -- directed, table-driven bench for dpram_rr_arbiter
// (NREQ=2) with a behavioural synchronous RAM model on the shared port.
// Honours DPRAM_ARB_CLEAR_EN for busy timing and the zero-fill check.
module tb_dpram_rr_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
`ifdef DPRAM_ARB_CLEAR_EN
  localparam int EXP_BUSY = 33;
`else
  localparam int EXP_BUSY = 1;
`endif

  logic              CLK;
  logic              RST;
  logic [NREQ-1:0]   req_valid, req_ready, req_we, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]     rsp_rdata, I, O;
  logic [AW-1:0]     A;
  logic              busy, CSB, WEB, OEB;

  int pass_cnt = 0;
  int total_cnt = 0;

  dpram_rr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .A(A), .I(I), .O(O), .CSB(CSB), .WEB(WEB), .OEB(OEB)
  );

  // Synchronous RAM port model: samples on posedge, read data next cycle.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] ram_q;
  always @(posedge CLK) begin
    if (!CSB) begin
      if (!WEB) mem[A] <= I;
      else      ram_q  <= mem[A];
    end
  end
  assign O = ram_q;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  v, we;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  ery, ersp;
    logic [31:0] edata;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(logic [1:0] v, logic [1:0] we, logic [4:0] a0, logic [4:0] a1,
                              logic [31:0] d0, logic [31:0] d1, logic [1:0] ery,
                              logic [1:0] ersp, logic [31:0] ed);
    vec_t r;
    r.v = v; r.we = we; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
    r.ery = ery; r.ersp = ersp; r.edata = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v; req_we = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  // Called at the negedge where RST was just released; counts edges until
  // busy drops and notes any response pulse on the way.
  task automatic wait_busy(input string name);
    int n;
    logic seen;
    n = 0; seen = 1'b0;
    while (busy && n < 100) begin
      step();
      n++;
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    chk(name, n, EXP_BUSY);
    chk({name, "_no_rsp"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    // Writes 0x0F/0x0A, reads back, alternating reads, write-then-read.
    tbl[0]  = mk(2'b01, 2'b01, 5'h0F, 5'h00, 32'h7B, 32'h0,  2'b01, 2'b00, 32'h0);
    tbl[1]  = mk(2'b10, 2'b10, 5'h00, 5'h0A, 32'h0,  32'h67, 2'b10, 2'b00, 32'h0);
    tbl[2]  = mk(2'b01, 2'b00, 5'h0A, 5'h00, 32'h0,  32'h0,  2'b01, 2'b00, 32'h0);
    tbl[3]  = mk(2'b00, 2'b00, 5'h00, 5'h00, 32'h0,  32'h0,  2'b00, 2'b00, 32'h0);
    tbl[4]  = mk(2'b01, 2'b00, 5'h0F, 5'h00, 32'h0,  32'h0,  2'b01, 2'b00, 32'h0);
    tbl[5]  = mk(2'b00, 2'b00, 5'h00, 5'h00, 32'h0,  32'h0,  2'b00, 2'b01, 32'h67);
    tbl[6]  = mk(2'b00, 2'b00, 5'h00, 5'h00, 32'h0,  32'h0,  2'b00, 2'b00, 32'h0);
    tbl[7]  = mk(2'b00, 2'b00, 5'h00, 5'h00, 32'h0,  32'h0,  2'b00, 2'b01, 32'h7B);
    tbl[8]  = mk(2'b11, 2'b00, 5'h0A, 5'h0F, 32'h0,  32'h0,  2'b10, 2'b00, 32'h0);
    tbl[9]  = mk(2'b11, 2'b00, 5'h0A, 5'h0F, 32'h0,  32'h0,  2'b01, 2'b00, 32'h0);
    tbl[10] = mk(2'b11, 2'b00, 5'h0A, 5'h0F, 32'h0,  32'h0,  2'b10, 2'b00, 32'h0);
    tbl[11] = mk(2'b01, 2'b00, 5'h0A, 5'h00, 32'h0,  32'h0,  2'b01, 2'b10, 32'h7B);
    tbl[12] = mk(2'b00, 2'b00, 5'h00, 5'h00, 32'h0,  32'h0,  2'b00, 2'b01, 32'h67);
    tbl[13] = mk(2'b00, 2'b00, 5'h00, 5'h00, 32'h0,  32'h0,  2'b00, 2'b10, 32'h7B);
    tbl[14] = mk(2'b00, 2'b00, 5'h00, 5'h00, 32'h0,  32'h0,  2'b00, 2'b01, 32'h67);
    tbl[15] = mk(2'b11, 2'b10, 5'h0F, 5'h0F, 32'h0,  32'h55, 2'b10, 2'b00, 32'h0);
    tbl[16] = mk(2'b01, 2'b00, 5'h0F, 5'h00, 32'h0,  32'h0,  2'b01, 2'b00, 32'h0);
    tbl[17] = mk(2'b00, 2'b00, 5'h00, 5'h00, 32'h0,  32'h0,  2'b00, 2'b00, 32'h0);
    tbl[18] = mk(2'b00, 2'b00, 5'h00, 5'h00, 32'h0,  32'h0,  2'b00, 2'b00, 32'h0);
    tbl[19] = mk(2'b00, 2'b00, 5'h00, 5'h00, 32'h0,  32'h0,  2'b00, 2'b01, 32'h55);

    // Reset state, with requests pending to prove ready stays low.
    RST = 1'b1;
    drive(2'b11, 2'b00, 5'h01, 5'h02, 32'h0, 32'h0);
    @(negedge CLK); #1;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_A", {27'd0, A}, 32'd0);
    chk("rst_I", I, 32'd0);
    chk("rst_pins", {29'd0, CSB, WEB, OEB}, 32'h7);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    @(negedge CLK);
    drive(2'b00, 2'b00, 5'h0, 5'h0, 32'h0, 32'h0);
    RST = 1'b0;
    wait_busy("busy_fall");

    // Main table.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      #1;
      chk($sformatf("v%0d_ready", i), {30'd0, req_ready}, {30'd0, tbl[i].ery});
      chk($sformatf("v%0d_rsp_valid", i), {30'd0, rsp_valid}, {30'd0, tbl[i].ersp});
      if (tbl[i].ersp != 2'b00) chk($sformatf("v%0d_rdata", i), rsp_rdata, tbl[i].edata);
      step();
    end

    // Ten idle cycles: port stays deselected, pointer left at requester 1.
    drive(2'b00, 2'b00, 5'h0, 5'h0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("idle%0d_csb_oeb", i), {30'd0, CSB, OEB}, 32'h3);
      step();
    end
    drive(2'b11, 2'b00, 5'h0A, 5'h0F, 32'h0, 32'h0);
    #1;
    chk("idle_ptr_held", {30'd0, req_ready}, 32'h2);
    step();
    // Second read in flight from requester 0, then reset mid-flight.
    drive(2'b01, 2'b00, 5'h0A, 5'h0F, 32'h0, 32'h0);
    #1;
    chk("flight2_ready", {30'd0, req_ready}, 32'h1);
    step();
    drive(2'b00, 2'b00, 5'h0, 5'h0, 32'h0, 32'h0);
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_pins", {29'd0, CSB, WEB, OEB}, 32'h7);
    chk("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("midrst_hold%0d_rsp", i), {30'd0, rsp_valid}, 32'd0);
    end
    RST = 1'b0;
    wait_busy("busy_fall2");

    // Pointer back at requester 0 after reset.
    drive(2'b11, 2'b00, 5'h01, 5'h02, 32'h0, 32'h0);
    #1;
    chk("ptr_after_rst", {30'd0, req_ready}, 32'h1);
    step();
    drive(2'b00, 2'b00, 5'h0, 5'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) step();

`ifdef DPRAM_ARB_CLEAR_EN
    // Every address reads back zero after the fill.
    for (int k = 0; k < 35; k++) begin
      if (k < 32) drive(2'b01, 2'b00, 5'(k), 5'h0, 32'h0, 32'h0);
      else        drive(2'b00, 2'b00, 5'h0, 5'h0, 32'h0, 32'h0);
      #1;
      if (k >= 3) begin
        chk($sformatf("clr%0d_rsp", k - 3), {30'd0, rsp_valid}, 32'h1);
        chk($sformatf("clr%0d_data", k - 3), rsp_rdata, 32'd0);
      end
      step();
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
